// File: rtl/mesh_path_allocator.sv
// mesh_path_allocator: XY/YX route allocation and link/ejection-port reservation for a ROWS x COLS mesh.
module mesh_path_allocator #(
  parameter int ROWS = 2,
  parameter int COLS = 2,
  parameter int LEN_W = 8,
  localparam int N = ROWS * COLS,
  localparam int NODE_W = (N > 1) ? $clog2(N) : 1,
  localparam int M = 5 * N
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N-1:0]        req_valid,
  input  logic [N*NODE_W-1:0] req_dst,
  input  logic [N*LEN_W-1:0]  req_len,
  output logic [N-1:0]        grant,
  output logic [N-1:0]        grant_route,
  output logic [N-1:0]        busy,
  output logic [N-1:0]        done,
  output logic [N-1:0]        req_err,
  output logic [4*N-1:0]      link_busy,
  output logic [N-1:0]        pe_busy
);
  // mask layout: bits 4n+{0:N,1:S,2:E,3:W} for router n, then bit 4N+d for ejection port d
  function automatic logic [M-1:0] path_mask(input int src, input int dst, input logic yx);
    int sr, sc, dr, dc, hr, vc, n;
    path_mask = '0;
    sr = src / COLS;
    sc = src % COLS;
    dr = dst / COLS;
    dc = dst % COLS;
    hr = yx ? dr : sr;
    vc = yx ? sc : dc;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        n = r * COLS + c;
        if (r == hr && c >= sc && c < dc) path_mask[4*n+2] = 1'b1;
        if (r == hr && c <= sc && c > dc) path_mask[4*n+3] = 1'b1;
        if (c == vc && r >= sr && r < dr) path_mask[4*n+0] = 1'b1;
        if (c == vc && r <= sr && r > dr) path_mask[4*n+1] = 1'b1;
      end
    if (dst < N) path_mask[4*N+dst] = 1'b1;
  endfunction

  logic [N-1:0]            active, cand, dst_ok;
  logic [N-1:0][LEN_W-1:0] cnt;
  logic [N-1:0][M-1:0]     mask, xy_m, yx_m;
  logic [M-1:0]            occ, win_mask;
  logic [NODE_W-1:0]       ptr, win;
  logic [LEN_W-1:0]        win_len;
  logic                    win_found, win_yx;

  always_comb begin
    occ = '0;
    for (int k = 0; k < N; k++) begin
      occ = occ | mask[k];
      done[k] = active[k] && cnt[k] == LEN_W'(1);
      dst_ok[k] = int'(req_dst[k*NODE_W +: NODE_W]) < N;
      xy_m[k] = path_mask(k, int'(req_dst[k*NODE_W +: NODE_W]), 1'b0);
      yx_m[k] = path_mask(k, int'(req_dst[k*NODE_W +: NODE_W]), 1'b1);
      cand[k] = req_valid[k] && !active[k] && dst_ok[k];
    end
  end

  // round-robin scan; a blocked candidate is skipped so later ones may still win
  always_comb begin
    int idx;
    idx = 0;
    win_found = 1'b0;
    win = '0;
    win_yx = 1'b0;
    win_mask = '0;
    win_len = '0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!win_found && cand[idx] && (xy_m[idx] & occ) == '0) begin
        win_found = 1'b1;
        win = NODE_W'(idx);
        win_yx = 1'b0;
        win_mask = xy_m[idx];
        win_len = req_len[idx*LEN_W +: LEN_W];
      end else if (!win_found && cand[idx] && (yx_m[idx] & occ) == '0) begin
        win_found = 1'b1;
        win = NODE_W'(idx);
        win_yx = 1'b1;
        win_mask = yx_m[idx];
        win_len = req_len[idx*LEN_W +: LEN_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      active <= '0;
      cnt <= '0;
      mask <= '0;
      ptr <= '0;
      grant <= '0;
      grant_route <= '0;
      req_err <= '0;
    end else begin
      grant <= '0;
      req_err <= req_valid & ~active & ~dst_ok;
      for (int k = 0; k < N; k++) begin
        if (active[k] && cnt[k] == LEN_W'(1)) begin
          active[k] <= 1'b0;
          mask[k] <= '0;
        end else if (active[k]) cnt[k] <= cnt[k] - LEN_W'(1);
      end
      if (win_found) begin
        active[win] <= 1'b1;
        cnt[win] <= (win_len == '0) ? LEN_W'(1) : win_len;
        mask[win] <= win_mask;
        grant[win] <= 1'b1;
        grant_route[win] <= win_yx;
        ptr <= (win == NODE_W'(N - 1)) ? '0 : win + NODE_W'(1);
      end
    end
  end

  assign busy = active;
  assign link_busy = occ[4*N-1:0];
  assign pe_busy = occ[M-1:4*N];
endmodule

// File: tb/tb_mesh_path_allocator.sv
// tb_mesh_path_allocator: directed checks of a 2x2 and a 2x3 allocator instance.
module tb_mesh_path_allocator;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst2, rst3;
  logic [3:0]  valid2, grant2, route2, busy2, done2, err2, pe2;
  logic [7:0]  dst2;
  logic [31:0] len2;
  logic [15:0] link2;
  logic [5:0]  valid3, grant3, route3, busy3, done3, err3, pe3;
  logic [17:0] dst3;
  logic [47:0] len3;
  logic [23:0] link3;

  mesh_path_allocator #(.ROWS(2), .COLS(2), .LEN_W(8)) u2 (
    .clock(clock), .reset(rst2), .req_valid(valid2), .req_dst(dst2), .req_len(len2),
    .grant(grant2), .grant_route(route2), .busy(busy2), .done(done2), .req_err(err2),
    .link_busy(link2), .pe_busy(pe2)
  );

  mesh_path_allocator #(.ROWS(2), .COLS(3), .LEN_W(8)) u3 (
    .clock(clock), .reset(rst3), .req_valid(valid3), .req_dst(dst3), .req_len(len3),
    .grant(grant3), .grant_route(route3), .busy(busy3), .done(done3), .req_err(err3),
    .link_busy(link3), .pe_busy(pe3)
  );

  typedef struct packed {
    logic        rst;
    logic [3:0]  valid;
    logic [7:0]  dst;
    logic [31:0] len;
    logic [3:0]  grant, route, busy, done, err;
    logic [15:0] link;
    logic [3:0]  pe;
  } vec_t;

  vec_t v[20];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step3(input logic r, input logic [5:0] vl, input logic [17:0] d, input logic [47:0] l);
    rst3 = r;
    valid3 = vl;
    dst3 = d;
    len3 = l;
    @(posedge clock);
    #1;
  endtask

  initial begin
    //        rst  valid dst    len            grant route busy done err  link      pe
    v[0]  = '{1'b0, 4'hF, 8'hE4, 32'h04040404, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0};
    v[1]  = '{1'b0, 4'hF, 8'hE4, 32'h04040404, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0};
    v[2]  = '{1'b1, 4'h1, 8'h03, 32'h00000004, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 16'h0014, 4'h8};
    v[3]  = '{1'b1, 4'h0, 8'h03, 32'h00000004, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 16'h0014, 4'h8};
    v[4]  = '{1'b1, 4'h0, 8'h03, 32'h00000004, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 16'h0014, 4'h8};
    v[5]  = '{1'b1, 4'h0, 8'h03, 32'h00000004, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 16'h0014, 4'h8};
    v[6]  = '{1'b1, 4'h0, 8'h03, 32'h00000004, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0};
    v[7]  = '{1'b0, 4'h0, 8'h00, 32'h00000000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0};
    v[8]  = '{1'b1, 4'h5, 8'h11, 32'h00020003, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 16'h0004, 4'h2};
    v[9]  = '{1'b1, 4'h4, 8'h11, 32'h00020003, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 16'h0004, 4'h2};
    v[10] = '{1'b1, 4'h4, 8'h11, 32'h00020003, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 16'h0004, 4'h2};
    v[11] = '{1'b1, 4'h4, 8'h11, 32'h00020003, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0};
    v[12] = '{1'b1, 4'h4, 8'h11, 32'h00020003, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0, 16'h2400, 4'h2};
    v[13] = '{1'b1, 4'h0, 8'h11, 32'h00020003, 4'h0, 4'h0, 4'h4, 4'h4, 4'h0, 16'h2400, 4'h2};
    v[14] = '{1'b1, 4'h0, 8'h11, 32'h00020003, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0};
    v[15] = '{1'b1, 4'h4, 8'h20, 32'h00000000, 4'h4, 4'h0, 4'h4, 4'h4, 4'h0, 16'h0000, 4'h4};
    v[16] = '{1'b1, 4'h0, 8'h20, 32'h00000000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0};
    v[17] = '{1'b1, 4'h1, 8'h03, 32'h00000002, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 16'h0014, 4'h8};
    v[18] = '{1'b0, 4'h1, 8'h03, 32'h00000002, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0};
    v[19] = '{1'b0, 4'h0, 8'h00, 32'h00000000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0};
    rst3 = 1'b0;
    valid3 = '0;
    dst3 = '0;
    len3 = '0;
    for (int i = 0; i < 20; i++) begin
      rst2 = v[i].rst;
      valid2 = v[i].valid;
      dst2 = v[i].dst;
      len2 = v[i].len;
      @(posedge clock);
      #1;
      chk($sformatf("v%0d grant", i), 64'(grant2), 64'(v[i].grant));
      chk($sformatf("v%0d route", i), 64'(route2), 64'(v[i].route));
      chk($sformatf("v%0d busy", i), 64'(busy2), 64'(v[i].busy));
      chk($sformatf("v%0d done", i), 64'(done2), 64'(v[i].done));
      chk($sformatf("v%0d req_err", i), 64'(err2), 64'(v[i].err));
      chk($sformatf("v%0d link_busy", i), 64'(link2), 64'(v[i].link));
      chk($sformatf("v%0d pe_busy", i), 64'(pe2), 64'(v[i].pe));
    end
    chk("m3 reset busy", 64'(busy3), 64'h0);
    chk("m3 reset link", 64'(link3), 64'h0);
    // 1->2 len 8 holds E1, forcing 0->5 onto its YX route
    step3(1'b1, 6'b000010, 18'h00010, 48'h000000000800);
    chk("m3 g1 grant", 64'(grant3), 64'h02);
    chk("m3 g1 link", 64'(link3), 64'h000040);
    chk("m3 g1 pe", 64'(pe3), 64'h04);
    step3(1'b1, 6'b000001, 18'h00005, 48'h000000000002);
    chk("m3 g0 grant", 64'(grant3), 64'h01);
    chk("m3 g0 route", 64'(route3), 64'h01);
    chk("m3 g0 link", 64'(link3), 64'h044041);
    chk("m3 g0 pe", 64'(pe3), 64'h24);
    step3(1'b1, 6'b001000, 18'h00C00, 48'h0);
    chk("m3 err1 req_err", 64'(err3), 64'h08);
    chk("m3 err1 grant", 64'(grant3), 64'h00);
    chk("m3 err1 busy", 64'(busy3), 64'h03);
    chk("m3 err1 done", 64'(done3), 64'h01);
    chk("m3 err1 link", 64'(link3), 64'h044041);
    step3(1'b1, 6'b001000, 18'h00C00, 48'h0);
    chk("m3 err2 req_err", 64'(err3), 64'h08);
    chk("m3 err2 grant", 64'(grant3), 64'h00);
    chk("m3 err2 busy", 64'(busy3), 64'h02);
    chk("m3 err2 route", 64'(route3), 64'h01);
    chk("m3 err2 link", 64'(link3), 64'h000040);
    chk("m3 err2 pe", 64'(pe3), 64'h04);
    step3(1'b1, 6'b000000, 18'h0, 48'h0);
    chk("m3 err3 req_err", 64'(err3), 64'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mesh_path_allocator.md
Name: mesh_path_allocator

Overview:
- Parametrised successor to the fixed 2x2 path-availability logic: a ROWS x COLS mesh route allocator and link-reservation tracker.
- Each processing unit requests a burst transfer to a destination node.
- The block picks XY routing, or YX when XY is blocked; reserves every directed router output link plus the destination ejection port for the burst; counts the burst down; then releases the reservations.
- Sits beside the master; drives grants and link/port occupancy that the master turns into router select/ready controls.

Parameters:
- ROWS, 2, mesh rows; node id = row*COLS + col, row 0 at the bottom, North = row+1, East = col+1.
- COLS, 2, mesh columns.
- LEN_W, 8, burst length width.
- N, ROWS*COLS, node count (derived, do not override).
- NODE_W, max(1,clog2(N)), node id width (derived).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  N  per-source transfer request, level.
- req_dst  in  N*NODE_W  destination of source k at [k*NODE_W +: NODE_W].
- req_len  in  N*LEN_W  burst length of source k; 0 is treated as 1.
- grant  out  N  one-cycle pulse: request of source k accepted.
- grant_route  out  N  route of the current/last grant of k: 0 = XY, 1 = YX.
- busy  out  N  source k transfer active.
- done  out  N  one-cycle pulse in the last busy cycle of source k.
- req_err  out  N  one-cycle pulse: req_dst >= N, request dropped.
- link_busy  out  4*N  reserved output links of router k: bit 4k+0 N, 4k+1 S, 4k+2 E, 4k+3 W.
- pe_busy  out  N  ejection (processor) port of node k reserved.

Behaviour:
- Reset (reset==0 at a clock edge): all sources IDLE; occupancy cleared; all outputs 0; round-robin pointer = 0. Applies mid-transfer, with no done pulse. Requests are ignored while reset is low.
- Per-source FSM:
  - IDLE -> ACTIVE on grant. Counter loaded with max(req_len,1); busy = 1.
  - ACTIVE: counter decrements each edge; done = 1 while counter == 1.
  - ACTIVE -> IDLE at the edge ending the done cycle; reservations clear at that same edge.
- req_valid on an ACTIVE source is ignored. req_dst/req_len are sampled only at the grant edge.
- Path masks are combinational from (src,dst):
  - XY: all East/West hops along the source row, then North/South hops along the destination column, plus pe[dst].
  - YX: vertical hops first, then horizontal, plus pe[dst].
  - src == dst: pe[dst] only, route = XY.
- Arbitration:
  - One grant per cycle.
  - Scan idle requesters round-robin starting at the pointer.
  - First candidate whose XY mask AND occupancy == 0 wins with route 0; else YX free wins with route 1; else skip it. No head-of-line blocking.
  - Pointer moves to winner+1 mod N.
  - Registered: request visible before edge E, so grant, busy, link_busy and pe_busy are high in the cycle after E.
- Arbitration uses registered occupancy. Links freed at edge E can be granted at edge E+1 at the earliest; there is no same-edge reuse.
- Invalid dst (>= N): req_err pulses the cycle after sampling; source stays IDLE, no reservation. It repeats each cycle while the request is held.
- Occupancy = OR of the masks of all ACTIVE sources. Granted masks are disjoint by construction.

Test Plan:
- Reset: hold reset = 0 with req_valid = 4'hF -> all outputs 0. Release reset, then assert 0->3 len 2 mid-burst and pull reset low -> next cycle busy, link_busy and pe_busy are all 0, with no done pulse.
- 2x2, 0->3 len 4 at edge E -> cycle E+1: grant[0] = 1, grant_route[0] = 0, link_busy = 16'h0014 (E0, N1), pe_busy = 4'h8. busy[0] high for 4 cycles with done in the 4th. All occupancy is 0 afterwards.
- 2x2, 0->1 len 3 and 2->1 len 2 in the same cycle, pointer 0 -> source 0 granted first. Source 2 is granted at the edge after source 0 releases: 1 idle cycle, then grant_route[2] = 0, link_busy bits 10 (E2) and 13 (S3).
- ROWS = 2, COLS = 3: 1->2 len 8 active (bit 6 = E1). Then 0->5 -> grant_route[0] = 1, link_busy adds bits 0, 14, 18 (N0, E3, E4), pe_busy[5] = 1.
- 2x2, 2->2 len 0 -> busy[2] for 1 cycle with done in the same cycle; pe_busy = 4'h4; link_busy = 0.
- ROWS = 2, COLS = 3, req_dst = 6 from source 3 -> req_err[3] pulse, no grant, occupancy unchanged.
